// File: rtl/serial_add.sv
// Bit-serial adder: a + b + cin through one full-adder cell, LSB first, WIDTH cycles per result.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             load;
   logic             step;
   logic             last;
   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] res_full;

   assign fa_s  = a_sh[0] ^ b_sh[0] ^ carry;
   assign fa_co = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
   assign last  = (cnt == CW'(WIDTH - 1));

   // The newest bit enters at the MSB; on the final bit this is the complete sum.
   assign res_full = {fa_s, res_sh};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         a_sh   <= a;
         b_sh   <= b;
         res_sh <= '0;
         carry  <= cin;
         cnt    <= '0;
      end else if (step) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         res_sh <= res_full[WIDTH-1:1];
         carry  <= fa_co;
         cnt    <= cnt + CW'(1);
      end
   end

   // Results are written only on the completion edge so partial sums never leak out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         sum  <= '0;
         cout <= 1'b0;
      end else begin
         busy <= (state_nxt == RUN);
         done <= step & last;
         if (step && last) begin
            sum  <= res_full;
            cout <= fa_co;
         end
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   // Carry into the MSB is the carry FF while the MSB is being processed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (step && last) begin
         ovf <= carry ^ fa_co;
      end
   end
`endif

endmodule

// File: tb/tb_serial_add.sv
// Randomized and directed bench for serial_add against a plain-arithmetic reference model.
module tb_serial_add;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int           n_chk;
   int           n_fail;
   logic [W-1:0] prev_sum;

   serial_add #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation from IDLE; intr >= 0 pulses a conflicting start that many cycles into RUN.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input int intr);
      logic [W:0] full;
      int         k;
      int         nb;
      int         bad;
      full  = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
      a     = av;
      b     = bv;
      cin   = ci;
      start = 1'b1;
      tick();
      start = 1'b0;
      k     = 0;
      nb    = 0;
      bad   = 0;
      while (!done && k < 40) begin
         if (busy) nb++;
         if (sum !== prev_sum) bad++;
         if (k == intr) begin
            start = 1'b1;
            a     = 8'hFF;
            b     = 8'hFF;
            cin   = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         k++;
      end
      start = 1'b0;
      check("latency", k, W);
      check("busy_cycles", nb, W);
      check("busy_at_done", busy, 0);
      check("sum_hidden", bad, 0);
      check("sum", sum, full[W-1:0]);
      check("cout", cout, full[W]);
`ifdef SERIAL_ADD_OVF_EN
      check("ovf", ovf, (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]));
`endif
      prev_sum = full[W-1:0];
      tick();
      check("done_pulse", done, 0);
      check("sum_hold", sum, prev_sum);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_done;
      int n_done;
      int gap_bad;
      int val_bad;
      int both_bad;
      int wait_cnt;

      n_chk    = 0;
      n_fail   = 0;
      prev_sum = '0;
      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      run_op(8'h55, 8'hAA, 1'b0, -1);
      run_op(8'hFF, 8'h01, 1'b0, -1);
      run_op(8'h00, 8'h00, 1'b1, -1);
      run_op(8'h7F, 8'h01, 1'b0, -1);
      run_op(8'h80, 8'h80, 1'b0, -1);
      run_op(8'h40, 8'h20, 1'b0, -1);
      run_op(8'hFF, 8'hFF, 1'b1, -1);

      // Conflicting start during RUN must be ignored.
      run_op(8'h12, 8'h34, 1'b0, 3);
      tick();
      check("no_second_done", done, 0);
      check("no_second_busy", busy, 0);

      // Reset in the middle of an operation.
      a     = 8'hF0;
      b     = 8'h0F;
      cin   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_cout", cout, 0);
      prev_sum = '0;
      tick();
      tick();
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) n_done++;
      end
      check("abort_no_done", n_done, 0);
      run_op(8'h01, 8'h01, 1'b0, -1);

      // Continuously held start: one result every W+1 cycles.
      a         = 8'h10;
      b         = 8'h20;
      cin       = 1'b0;
      start     = 1'b1;
      last_done = -1;
      n_done    = 0;
      gap_bad   = 0;
      val_bad   = 0;
      both_bad  = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (busy && done) both_bad++;
         if (done) begin
            n_done++;
            if (sum !== 8'h30) val_bad++;
            if (last_done >= 0 && (c - last_done) != W + 1) gap_bad++;
            last_done = c;
         end
      end
      start = 1'b0;
      check("held_done_count", n_done, 6);
      check("held_gap", gap_bad, 0);
      check("held_sum", val_bad, 0);
      check("held_overlap", both_bad, 0);
      wait_cnt = 0;
      while ((busy || done) && wait_cnt < 40) begin
         tick();
         wait_cnt++;
      end
      check("held_drain", busy, 0);
      prev_sum = 8'h30;
      tick();

      for (int i = 0; i < 30; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(1)),
                ($urandom_range(3) == 0) ? int'($urandom_range(W - 2)) : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add.md
# serial_add

Bit-serial two's-complement adder: the additive counterpart of the team's combinational full subtractor, computing `a + b + cin` one bit per clock through a single full-adder cell and a carry flip-flop. Operands are loaded in parallel on a start pulse, processed LSB first, and the parallel result is presented with a one-cycle `done` pulse. It sits alongside the subtractor in the arithmetic library as the area-minimal adder for multi-cycle datapaths.

## Interface
- `WIDTH`, default 8: operand and result width in bits, minimum 2.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request. Sampled only in IDLE.
- `a`  input  WIDTH  augend. Captured on an accepted start.
- `b`  input  WIDTH  addend. Captured on an accepted start.
- `cin`  input  1  carry-in. Captured on an accepted start.
- `busy`  output  1  high while an addition is in progress.
- `done`  output  1  single-cycle pulse when `sum`/`cout` become valid.
- `sum`  output  WIDTH  result. Held until the next accepted start completes.
- `cout`  output  1  carry out of the MSB.
- `ovf`  output  1  signed overflow. Present only with `SERIAL_ADD_OVF_EN`.

## Operation
- FSM states: IDLE, RUN.
- IDLE with `start`=1:
  - load `a`, `b` into operand shift registers.
  - load `cin` into the carry FF.
  - clear the bit counter.
  - go to RUN.
  - `busy`=1 from the next cycle.
- RUN, each cycle:
  - full-adder on the operand LSBs and the carry FF: `s = a0^b0^c`, `co = a0&b0 | (a0^b0)&c`.
  - `s` shifts into the result register MSB (result shifts right).
  - operands shift right.
  - carry FF takes `co`.
  - counter increments.
- On the cycle processing bit WIDTH-1:
  - write the final sum and `cout`.
  - assert `done` for exactly one cycle.
  - return to IDLE; `busy` deasserts in the same cycle `done` rises.
- `start` while in RUN is ignored. There is no queuing and captured operands are not disturbed.
- `start` held high continuously: a new operation is accepted in the first IDLE cycle after `done`, so back-to-back throughput is one result per WIDTH+1 cycles.
- `sum`/`cout` change only on the completion edge. Intermediate shift state is internal and is never visible on `sum`.
- Arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on `cout`.
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - shift registers, carry FF and counter cleared.
- Reset during RUN aborts the operation. No `done` is issued and the outputs return to 0.

## Timing
- Accepting edge is T0: `start`=1 sampled in IDLE.
- `busy`=1 during the cycles after edges T0 … T0+WIDTH-1.
- Bit i is computed on edge T0+1+i.
- `done`=1, with `sum`/`cout`/`ovf` valid, during the cycle after edge T0+WIDTH. Latency is WIDTH cycles from the accepting edge.
- `done` and `busy` are never high in the same cycle.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - adds the `ovf` output port.
  - `ovf` is written with `done` as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
  - `ovf` holds alongside `sum` and resets to 0.
- Not defined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, `a`=0x55, `b`=0xAA, `cin`=0 → `done` exactly 8 cycles after the accepting edge, `sum`=0xFF, `cout`=0; `busy` high for 8 cycles.
- `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1. Then `a`=0x00, `b`=0x00, `cin`=1 → `sum`=0x01, `cout`=0.
- Start 0x12+0x34; pulse `start` again with 0xFF+0xFF at cycle 3 → second request ignored, `sum`=0x46, one `done` only.
- Start 0xF0+0x0F; drive `rst_n`=0 at cycle 4 → all outputs 0 immediately, no `done`. After release, 0x01+0x01 → `sum`=0x02.
- `start` held high with constant 0x10+0x20 → `done` pulses every 9 cycles, `sum`=0x30 each time.
- With `SERIAL_ADD_OVF_EN`: 0x7F+0x01 → `sum`=0x80, `ovf`=1, `cout`=0. 0x80+0x80 → `sum`=0x00, `ovf`=1, `cout`=1. 0x40+0x20 → `ovf`=0.
